// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - encodings and constants shared by the uart frame transmitter and receiver
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_OPT,
    ST_LEN,
    ST_DATA_WAIT,
    ST_DATA,
    ST_CSM
  } state_e;

  localparam logic [6:0]  INIT_PATTERN = 7'h7E;
  localparam int          CSM_BYTE_NUM = 4;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_bit_serial.sv
// rtl/crc32_bit_serial.sv - MSB-first bit-serial CRC-32, clr reloads the seed
module crc32_bit_serial
  import uart_frame_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        bit_valid,
  input  logic        in_bit,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (bit_valid) begin
      crc_d = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ in_bit) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - serial frame transmitter: init, opt, len, payload and CRC-32, one bit per clock
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int BYTE_SIZE  = 8,
  parameter int INIT_WIDTH = 7,
  parameter int GAP_MAX    = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [BYTE_SIZE-1:0] opt,
  input  logic [BYTE_SIZE-1:0] len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [BYTE_SIZE-1:0] data,
  output logic                 out_bit,
  output logic                 out_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = $clog2((INIT_WIDTH > BYTE_SIZE ? INIT_WIDTH : BYTE_SIZE) + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BYTE_SIZE);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_MAX - 1);
  localparam logic [1:0]       CSM_LAST  = 2'(CSM_BYTE_NUM - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INIT_WIDTH-1:0] init_sr_q, init_sr_d;
  logic [BYTE_SIZE-1:0]  byte_q, byte_d;
  logic [BYTE_SIZE-1:0]  len_q, len_d;
  logic [BYTE_SIZE-1:0]  data_cnt_q, data_cnt_d;
  logic [31:0]           csm_sr_q, csm_sr_d;
  logic [1:0]            csm_idx_q, csm_idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  out_bit_q, out_bit_d;
  logic                  out_en_q, out_en_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic        start_acc, data_acc, byte_last, data_final;
  logic        crc_bit_valid;
  logic [31:0] crc;

  assign start_ready = (state_q == ST_IDLE);
  assign start_acc   = start_valid && start_ready;
  assign byte_last   = (cnt_q == BIT_LAST);
  assign data_final  = (data_cnt_q == len_q);

  always_comb begin
    data_ready = 1'b0;
    if (state_q == ST_DATA_WAIT) begin
      data_ready = 1'b1;
    end else if (byte_last && (state_q == ST_LEN || (state_q == ST_DATA && !data_final))) begin
      data_ready = 1'b1;
    end
  end

  assign data_acc = data_valid && data_ready;

  // The line bit itself feeds the CRC, so only the data bits of opt/len/payload count.
  assign crc_bit_valid = (state_q == ST_OPT || state_q == ST_LEN || state_q == ST_DATA) &&
                         (cnt_q != '0);

  crc32_bit_serial u_crc (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (start_acc),
    .bit_valid (crc_bit_valid),
    .in_bit    (out_bit_q),
    .crc       (crc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_sr_d  = init_sr_q;
    byte_d     = byte_q;
    len_d      = len_q;
    data_cnt_d = data_cnt_q;
    csm_sr_d   = csm_sr_q;
    csm_idx_d  = csm_idx_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    out_bit_d  = 1'b1;
    out_en_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          if (len != '0) begin
            state_d    = ST_INIT;
            cnt_d      = '0;
            init_sr_d  = INIT_WIDTH'(INIT_PATTERN);
            byte_d     = opt;
            len_d      = len;
            data_cnt_d = '0;
            csm_idx_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_OPT;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          init_sr_d = init_sr_q << 1;
        end
      end
      ST_OPT, ST_LEN, ST_DATA: begin
        if (!byte_last) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q != '0) begin
            byte_d = byte_q << 1;
          end
        end else if (state_q == ST_OPT) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          byte_d  = len_q;
        end else if (state_q == ST_DATA && data_final) begin
          state_d = ST_CSM;
          cnt_d   = '0;
        end else if (data_acc) begin
          state_d    = ST_DATA;
          cnt_d      = '0;
          byte_d     = data;
          data_cnt_d = data_cnt_q + 1'b1;
          gap_d      = '0;
        end else begin
          state_d = ST_DATA_WAIT;
          gap_d   = '0;
        end
      end
      ST_DATA_WAIT: begin
        if (data_acc) begin
          state_d    = ST_DATA;
          cnt_d      = '0;
          byte_d     = data;
          data_cnt_d = data_cnt_q + 1'b1;
          gap_d      = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_CSM: begin
        // The CRC settles during the first CSM start bit; load it when leaving that bit.
        if (cnt_q != '0) begin
          csm_sr_d = csm_sr_q << 1;
        end else if (csm_idx_q == '0) begin
          csm_sr_d = crc;
        end
        if (!byte_last) begin
          cnt_d = cnt_q + 1'b1;
        end else if (csm_idx_q == CSM_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d     = '0;
          csm_idx_d = csm_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_en_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_INIT:                 out_bit_d = init_sr_d[INIT_WIDTH-1];
      ST_OPT, ST_LEN, ST_DATA: out_bit_d = (cnt_d == '0) ? 1'b0 : byte_d[BYTE_SIZE-1];
      ST_CSM:                  out_bit_d = (cnt_d == '0) ? 1'b0 : csm_sr_d[31];
      default:                 out_bit_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      init_sr_q  <= '0;
      byte_q     <= '0;
      len_q      <= '0;
      data_cnt_q <= '0;
      csm_sr_q   <= '0;
      csm_idx_q  <= '0;
      gap_q      <= '0;
      out_bit_q  <= 1'b1;
      out_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_sr_q  <= init_sr_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      data_cnt_q <= data_cnt_d;
      csm_sr_q   <= csm_sr_d;
      csm_idx_q  <= csm_idx_d;
      gap_q      <= gap_d;
      out_bit_q  <= out_bit_d;
      out_en_q   <= out_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign out_bit = out_bit_q;
  assign out_en  = out_en_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule
